// File: rtl/multiword_add_ctrl_pkg.sv
// rtl/multiword_add_ctrl_pkg.sv - shared slice width and sequencer state encoding
package adder_ctrl_pkg;

  // Width of one adder slice; operands are NUM_WORDS of these
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } add_state_t;

endpackage

// File: rtl/multiword_add_ctrl_if.sv
// rtl/multiword_add_ctrl_if.sv - host start/done bus of the multiword add sequencer
interface multiword_add_ctrl_if
  import adder_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = 4
) ();

  localparam int W = WORD_W * NUM_WORDS;

  logic         start;
  logic         clear;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;

  // Host side drives requests and operands, observes status and sum
  modport master (
    output start, clear, a_in, b_in, carry_in,
    input  busy, done, result, overflow
  );

  // Sequencer side
  modport slave (
    input  start, clear, a_in, b_in, carry_in,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/adder_16bit.sv
// rtl/adder_16bit.sv - one 16-bit unsigned adder slice with carry in/out
module adder_16bit
  import adder_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              carry_in,
  output logic [WORD_W-1:0] sum,
  output logic              overflow
);

  // Sum is one bit wider than a slice; the extra bit is the carry out
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, carry_in};

endmodule

// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - wide add sequenced one 16-bit slice per clock on a single adder
module multiword_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  multiword_add_ctrl_if.slave  ctrl
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  add_state_t state;
  add_state_t state_nxt;

  // Operands and result viewed as arrays of slices so idx selects a slice directly
  logic [NUM_WORDS-1:0][WORD_W-1:0] a_reg;
  logic [NUM_WORDS-1:0][WORD_W-1:0] b_reg;
  logic [NUM_WORDS-1:0][WORD_W-1:0] result_reg;
  logic [IDX_W-1:0]                 idx;
  logic                             carry;
  logic                             overflow_reg;

  logic              accept;
  logic              step;
  logic              last;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] slice_sum;
  logic              slice_ovf;

  adder_16bit u_adder (
    .a        (a_reg[idx]),
    .b        (b_reg[idx]),
    .carry_in (carry),
    .sum      (slice_sum),
    .overflow (slice_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: clear always forces IDLE, otherwise walk IDLE -> ADD -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ctrl.clear) state_nxt = IDLE;
  end

  // Moore status plus the datapath strobes; clear suppresses both accept and step
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: accept = ctrl.start & ~ctrl.clear;
      ADD: begin
        busy = 1'b1;
        step = ~ctrl.clear;
        last = (idx == LAST_IDX);
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, then write one slice per ADD cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      idx          <= '0;
      carry        <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (ctrl.clear) begin
      result_reg   <= '0;
      idx          <= '0;
      carry        <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      a_reg        <= ctrl.a_in;
      b_reg        <= ctrl.b_in;
      carry        <= ctrl.carry_in;
      result_reg   <= '0;
      idx          <= '0;
      overflow_reg <= 1'b0;
    end else if (step) begin
      result_reg[idx] <= slice_sum;
      carry           <= slice_ovf;
      if (last) overflow_reg <= slice_ovf;
      else      idx          <= idx + 1'b1;
    end
  end

  assign ctrl.busy     = busy;
  assign ctrl.done     = done;
  assign ctrl.result   = result_reg;
  assign ctrl.overflow = overflow_reg;

endmodule
